// File: rtl/tribus_seq_if.sv
// Bus bundle between the upstream producer/consumer and tribus_seq.
// Contents: the write byte stream, the read request/response, and the RAM
// array pins (address, data, write enables, bank select, read bus).
// The master side also hosts the array's read bus (qin), since the array
// sits on the same side of the sequencer as the requester.
interface tribus_seq_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       clr;
    logic       rd_start;
    logic [8:0] rd_base;
    logic [9:0] rd_len;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       full;
    logic [6:0] a;
    logic [7:0] d;
    logic       wren1;
    logic       wren2;
    logic       wren3;
    logic       wren4;
    logic [1:0] ena;
    logic [7:0] qin;

    modport master (
        output wr_valid, wr_data, clr, rd_start, rd_base, rd_len, qin,
        input  wr_ready, rd_valid, rd_data, busy, full,
               a, d, wren1, wren2, wren3, wren4, ena
    );

    modport slave (
        input  wr_valid, wr_data, clr, rd_start, rd_base, rd_len, qin,
        output wr_ready, rd_valid, rd_data, busy, full,
               a, d, wren1, wren2, wren3, wren4, ena
    );
endinterface

// File: rtl/tribus_seq.sv
// tribus_seq: upstream sequencer for a 4-bank x 128 x 8 tristate RAM array.
// The write side fills the banks linearly from a byte stream; the read side
// sweeps a block of linear addresses, steering the bank mux (ena) so that it
// lines up with the array's read latency, and returns bytes on rd_data.
// This block is the only driver of a, d, wren1..4 and ena.
module tribus_seq #(
    parameter int RD_LAT = 1          // array read latency in cycles, 1..3
) (
    input  logic        clk,
    input  logic        rst_n,
    tribus_seq_if.slave bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]              state_reg;
    logic [1:0]              state_next;
    logic [9:0]              wptr_reg;
    logic [8:0]              raddr_reg;
    logic [9:0]              remaining_reg;
    logic [6:0]              a_reg;
    logic [7:0]              d_reg;
    logic [3:0]              wren_reg;
    logic [3:0]              wren_next;
    logic [1:0]              ena_reg;
    logic                    rd_valid_reg;
    logic [7:0]              rd_data_reg;
    // Stage k is set during the (k+1)-th cycle after an address was issued.
    logic [RD_LAT:0]         vld_pipe_reg;
    logic [RD_LAT-1:0][1:0]  bank_pipe_reg;

    logic       idle;
    logic       full;
    logic       wr_ready;
    logic       do_clr;
    logic       do_write;
    logic       start;
    logic       issue_now;
    logic       pipe_empty;
    logic [8:0] issue_addr;

    assign idle       = (state_reg == ST_IDLE);
    assign full       = (wptr_reg == 10'd512);
    // A read request in the same cycle takes priority over a write.
    assign wr_ready   = idle & ~full & ~bus.rd_start;
    // Rewind beats a same-cycle write; that byte is dropped.
    assign do_clr     = idle & bus.clr;
    assign do_write   = bus.wr_valid & wr_ready & ~do_clr;
    assign start      = idle & bus.rd_start & (bus.rd_len != 10'd0);
    // The first address goes out on the very edge that accepts the request,
    // which is what makes the first rd_valid land RD_LAT+2 cycles later.
    assign issue_now  = start | (state_reg == ST_ISSUE);
    assign issue_addr = start ? bus.rd_base : raddr_reg;
    assign pipe_empty = (vld_pipe_reg == '0);

    // One-hot bank write enable decoded from the write pointer's bank bits.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wren
            assign wren_next[gi] = do_write & (wptr_reg[8:7] == 2'(gi));
        end
    endgenerate

    // Next-state decode for the read sequencer.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = (bus.rd_len == 10'd1) ? ST_DRAIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (remaining_reg == 10'd1) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Read sequencer state, next read address and count still to issue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            raddr_reg     <= '0;
            remaining_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (start) begin
                raddr_reg     <= bus.rd_base + 9'd1;
                remaining_reg <= bus.rd_len - 10'd1;
            end else if (state_reg == ST_ISSUE) begin
                // 9-bit add wraps bank3/addr127 back to bank0/addr0.
                raddr_reg     <= raddr_reg + 9'd1;
                remaining_reg <= remaining_reg - 10'd1;
            end
        end
    end

    // Linear write pointer; saturates at 512 (full), never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_reg <= '0;
        end else if (do_clr) begin
            wptr_reg <= '0;
        end else if (do_write) begin
            wptr_reg <= wptr_reg + 10'd1;
        end
    end

    // Array address/data/write-enable registers shared by writes and reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            d_reg    <= '0;
            wren_reg <= '0;
        end else begin
            wren_reg <= wren_next;
            if (issue_now) begin
                a_reg <= issue_addr[6:0];
            end else if (do_write) begin
                a_reg <= wptr_reg[6:0];
                d_reg <= bus.wr_data;
            end
        end
    end

    // Tracks issued addresses (valid + bank) through the array latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_reg  <= '0;
            bank_pipe_reg <= '0;
        end else begin
            vld_pipe_reg     <= {vld_pipe_reg[RD_LAT-1:0], issue_now};
            bank_pipe_reg[0] <= issue_addr[8:7];
            for (int i = 1; i < RD_LAT; i++) begin
                bank_pipe_reg[i] <= bank_pipe_reg[i-1];
            end
        end
    end

    // Bank mux select timed to the array output, then capture of qin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_reg      <= '0;
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            // ena keeps its last bank when nothing is in flight.
            if (vld_pipe_reg[RD_LAT-1]) begin
                ena_reg <= bank_pipe_reg[RD_LAT-1];
            end
            rd_valid_reg <= vld_pipe_reg[RD_LAT];
            if (vld_pipe_reg[RD_LAT]) begin
                rd_data_reg <= bus.qin;
            end
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.full     = full;
    assign bus.busy     = ~idle;
    assign bus.a        = a_reg;
    assign bus.d        = d_reg;
    assign bus.wren1    = wren_reg[0];
    assign bus.wren2    = wren_reg[1];
    assign bus.wren3    = wren_reg[2];
    assign bus.wren4    = wren_reg[3];
    assign bus.ena      = ena_reg;
    assign bus.rd_valid = rd_valid_reg;
    assign bus.rd_data  = rd_data_reg;

endmodule

// File: tb/tb_tribus_seq.sv
// Testbench for tribus_seq: directed and randomized writes and reads checked
// against a linear 512-byte reference memory and the cycle timing of the
// read sweep (first byte RD_LAT+2 after the request, contiguous bytes).
module tb_tribus_seq;

    localparam int RD_LAT = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tribus_seq_if bus ();

    tribus_seq #(.RD_LAT(RD_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Environment: the 4-bank array, read latency RD_LAT from registered a.
    logic [7:0]            arr [0:511];
    logic [RD_LAT-1:0][6:0] a_hist;

    always @(posedge clk) begin
        if (bus.wren1) arr[{2'd0, bus.a}] <= bus.d;
        if (bus.wren2) arr[{2'd1, bus.a}] <= bus.d;
        if (bus.wren3) arr[{2'd2, bus.a}] <= bus.d;
        if (bus.wren4) arr[{2'd3, bus.a}] <= bus.d;
        a_hist[0] <= bus.a;
        for (int i = 1; i < RD_LAT; i++) a_hist[i] <= a_hist[i-1];
    end

    assign bus.qin = arr[{bus.ena, a_hist[RD_LAT-1]}];

    // Reference model: what has been stored at each linear address.
    logic [7:0] ref_mem [0:511];
    int exp_wptr = 0;
    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] wren_vec();
        return {bus.wren4, bus.wren3, bus.wren2, bus.wren1};
    endfunction

    // Offer one byte (after 'gap' idle cycles); checks the array write that
    // follows an accept, or that nothing is written while full (4 tries).
    task automatic write_one(input logic [7:0] b, input int gap);
        int tries;
        for (int g = 0; g < gap; g++) begin
            bus.wr_valid = 1'b0;
            @(posedge clk); #1;
            check("gap_wren", 32'(wren_vec()), 32'd0);
        end
        tries = 0;
        bus.wr_valid = 1'b1;
        bus.wr_data  = b;
        while (tries < 4) begin
            @(negedge clk);
            check("wr_ready", 32'(bus.wr_ready), 32'(exp_wptr < 512));
            check("full", 32'(bus.full), 32'(exp_wptr == 512));
            @(posedge clk); #1;
            if (exp_wptr < 512) begin
                check("wr_a", 32'(bus.a), 32'(exp_wptr % 128));
                check("wr_d", 32'(bus.d), 32'(b));
                check("wr_wren", 32'(wren_vec()), 32'(1 << (exp_wptr / 128)));
                $display("write byte 0x%02h at linear %0d", b, exp_wptr);
                ref_mem[exp_wptr] = b;
                exp_wptr++;
                tries = 4;
            end else begin
                check("held_wren", 32'(wren_vec()), 32'd0);
                tries++;
            end
        end
    endtask

    // CLR together with a write offer: the byte must be dropped.
    task automatic clr_with_byte();
        bus.clr      = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'hC3;
        @(posedge clk); #1;
        bus.clr      = 1'b0;
        bus.wr_valid = 1'b0;
        check("clr_wren", 32'(wren_vec()), 32'd0);
        exp_wptr = 0;
        @(negedge clk);
        check("clr_full", 32'(bus.full), 32'd0);
        check("clr_ready", 32'(bus.wr_ready), 32'd1);
        @(posedge clk); #1;
        $display("clear write pointer");
    endtask

    // One read sweep; cycle 0 is the rd_start cycle.
    task automatic do_read(input int base, input int len, input bit with_wr, input bit poke);
        int last;
        int k;
        int idx;
        bit in_win;
        last = len + RD_LAT + 4;
        bus.rd_start = 1'b1;
        bus.rd_base  = 9'(base);
        bus.rd_len   = 10'(len);
        bus.wr_valid = with_wr;
        bus.wr_data  = 8'h5A;
        @(negedge clk);
        check("start_wr_ready", 32'(bus.wr_ready), 32'd0);
        @(posedge clk); #1;
        bus.rd_start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            if (poke && c == 2) begin
                bus.rd_start = 1'b1;
                bus.rd_base  = 9'd7;
                bus.rd_len   = 10'd3;
            end
            if (c == len) bus.wr_valid = 1'b0;
            @(negedge clk);
            in_win = (c >= RD_LAT + 2) && (c < RD_LAT + 2 + len);
            check("rd_valid", 32'(bus.rd_valid), 32'(in_win));
            if (in_win) begin
                k   = c - RD_LAT - 2;
                idx = (base + k) % 512;
                check("rd_data", 32'(bus.rd_data), 32'(ref_mem[idx]));
                $display("read linear %0d data 0x%02h", idx, bus.rd_data);
            end
            if (c <= len) begin
                check("rd_a", 32'(bus.a), 32'(((base + c - 1) % 512) % 128));
                check("rd_busy", 32'(bus.busy), 32'd1);
                check("rd_wr_ready", 32'(bus.wr_ready), 32'd0);
            end
            if (c >= RD_LAT + 1 && c <= RD_LAT + len) begin
                check("rd_ena", 32'(bus.ena), 32'(((base + c - RD_LAT - 1) % 512) / 128));
            end
            if (c <= len + RD_LAT + 1) begin
                check("rd_no_wren", 32'(wren_vec()), 32'd0);
            end
            @(posedge clk); #1;
            bus.rd_start = 1'b0;
        end
        @(negedge clk);
        check("rd_done_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.clr      = 1'b0;
        bus.rd_start = 1'b0;
        bus.rd_base  = '0;
        bus.rd_len   = '0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", 32'(bus.a), 32'd0);
        check("rst_d", 32'(bus.d), 32'd0);
        check("rst_wren", 32'(wren_vec()), 32'd0);
        check("rst_ena", 32'(bus.ena), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Three back-to-back writes into bank 0
        write_one(8'h11, 0);
        write_one(8'h22, 0);
        write_one(8'h33, 0);
        bus.wr_valid = 1'b0;
        @(posedge clk); #1;
        check("t1_wren_off", 32'(wren_vec()), 32'd0);

        // 130 bytes crossing from bank 0 into bank 1
        clr_with_byte();
        for (int i = 0; i < 130; i++) write_one(8'(i), 0);
        bus.wr_valid = 1'b0;

        // Read across the bank 0 / bank 1 boundary
        do_read(126, 4, 1'b0, 1'b0);

        // Zero-length request is a no-op
        bus.rd_start = 1'b1;
        bus.rd_base  = 9'd5;
        bus.rd_len   = 10'd0;
        @(posedge clk); #1;
        bus.rd_start = 1'b0;
        for (int c = 0; c < RD_LAT + 4; c++) begin
            @(negedge clk);
            check("len0_busy", 32'(bus.busy), 32'd0);
            check("len0_valid", 32'(bus.rd_valid), 32'd0);
            @(posedge clk); #1;
        end

        // Full fill, then byte 513 is held off
        clr_with_byte();
        for (int i = 0; i < 512; i++) write_one(8'(i), 0);
        write_one(8'hEE, 0);
        bus.wr_valid = 1'b0;

        // Wrap from bank 3 back to bank 0, whole-array sweep, single byte
        do_read(510, 4, 1'b0, 1'b0);
        do_read(0, 512, 1'b0, 1'b1);
        do_read(200, 1, 1'b0, 1'b0);

        // Rewind from full; next write lands at bank 0 address 0
        clr_with_byte();
        write_one(8'h5C, 0);

        // Randomized writes with idle gaps, then random reads
        n = int'($urandom_range(150, 400));
        for (int i = 0; i < n; i++) write_one(8'($urandom), int'($urandom_range(0, 2)));
        bus.wr_valid = 1'b0;
        for (int r = 0; r < 6; r++) begin
            do_read(int'($urandom_range(0, 511)), int'($urandom_range(1, 40)), 1'b0, 1'b0);
        end

        // Read request with a write offered in the same cycle
        do_read(int'($urandom_range(0, 511)), 8, 1'b1, 1'b0);

        // Reset in the middle of a read
        bus.rd_start = 1'b1;
        bus.rd_base  = 9'd300;
        bus.rd_len   = 10'd20;
        bus.wr_valid = 1'b1;
        @(negedge clk);
        check("t6_wr_ready", 32'(bus.wr_ready), 32'd0);
        @(posedge clk); #1;
        bus.rd_start = 1'b0;
        bus.wr_valid = 1'b0;
        repeat (RD_LAT + 3) @(posedge clk);
        #1;
        check("t6_mid_valid", 32'(bus.rd_valid), 32'd1);
        check("t6_mid_busy", 32'(bus.busy), 32'd1);
        check("t6_mid_ena", 32'(bus.ena), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("t6_rst_busy", 32'(bus.busy), 32'd0);
        check("t6_rst_a", 32'(bus.a), 32'd0);
        check("t6_rst_d", 32'(bus.d), 32'd0);
        check("t6_rst_ena", 32'(bus.ena), 32'd0);
        check("t6_rst_full", 32'(bus.full), 32'd0);
        exp_wptr = 0;
        $display("reset asserted mid-read");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("t6_after_valid", 32'(bus.rd_valid), 32'd0);
            check("t6_after_busy", 32'(bus.busy), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
